// File: rtl/fanout_pkg.sv
// Shared types and defaults for the ready/valid fanout fork.
package fanout_pkg;

    localparam int unsigned SEL_BIT_DEFAULT   = 6;
    localparam int unsigned SEL_WIDTH_DEFAULT = 8;

    typedef enum logic {
        FORK_LAZY  = 1'b0,
        FORK_EAGER = 1'b1
    } fork_mode_e;

    typedef logic [SEL_WIDTH_DEFAULT-1:0] sel_t;

endpackage

// File: rtl/fanout_branch_tracker.sv
// Per-branch valid generation, ready contribution and "already sent" tracking.
module fanout_branch_tracker
    import fanout_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  fork_mode_e mode,
    input  logic       active,
    input  logic       in_valid,
    input  logic       out_ready,
    input  logic       complete,
    input  logic       all_ok,
    output logic       out_valid,
    output logic       done,
    output logic       ready_term
);

    logic done_r;
    logic done_nxt_s;
    logic fire_s;

    // Branch valid and the branch's vote towards the upstream ready.
    // The ready term never looks at in_valid or all_ok, so the AND in the
    // top cannot form a combinational loop through out_valid.
    always_comb begin
        out_valid  = 1'b0;
        ready_term = 1'b1;
        if (mode == FORK_EAGER) begin
            out_valid  = in_valid & active & ~done_r;
            ready_term = ~active | done_r | out_ready;
        end else begin
            out_valid  = in_valid & active & all_ok;
            ready_term = ~active | out_ready;
        end
    end

    assign fire_s = out_valid & out_ready;

    // Next done state: flush wins, lazy mode never tracks, completion retires the token.
    always_comb begin
        done_nxt_s = done_r;
        if (flush) begin
            done_nxt_s = 1'b0;
        end else if (mode == FORK_LAZY) begin
            done_nxt_s = 1'b0;
        end else if (complete) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r | fire_s;
        end
    end

    // Done register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r <= 1'b0;
        end else begin
            done_r <= done_nxt_s;
        end
    end

    assign done = done_r;

endmodule

// File: rtl/fanout_fork.sv
// Ready/valid fork broadcasting one upstream stream to NUM_FANOUT branches,
// with optional eager per-branch tracking and a saturating stall counter.
module fanout_fork
    import fanout_pkg::*;
#(
    parameter int unsigned NUM_FANOUT = 20,
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned SEL_WIDTH  = SEL_WIDTH_DEFAULT,
    parameter int unsigned SEL_BIT    = SEL_BIT_DEFAULT,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          mode_eager,
    input  logic [NUM_FANOUT-1:0]         en,
    input  logic [NUM_FANOUT*SEL_WIDTH-1:0] sel,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          in_ready,
    output logic [NUM_FANOUT-1:0]         out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic [NUM_FANOUT-1:0]         out_ready,
    output logic [NUM_FANOUT-1:0]         done_mask,
    output logic [CNT_WIDTH-1:0]          stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    fork_mode_e            mode_s;
    logic [NUM_FANOUT-1:0] active_s;
    logic [NUM_FANOUT-1:0] ready_terms_s;
    logic                  complete_s;
    logic                  stall_s;
    logic [CNT_WIDTH-1:0]  stall_cnt_r;
    logic                  sel_unused_s;

    assign mode_s = mode_eager ? FORK_EAGER : FORK_LAZY;

    // Only one bit of each select field matters; the rest are folded away here.
    assign sel_unused_s = ^sel;

    assign out_data   = in_data;
    assign in_ready   = &ready_terms_s;
    assign complete_s = in_valid & in_ready;
    assign stall_s    = in_valid & ~in_ready;

    for (genvar i = 0; i < NUM_FANOUT; i++) begin : g_branch
        assign active_s[i] = en[i] & sel[i*SEL_WIDTH + SEL_BIT];

        fanout_branch_tracker u_tracker (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .mode       (mode_s),
            .active     (active_s[i]),
            .in_valid   (in_valid),
            .out_ready  (out_ready[i]),
            .complete   (complete_s),
            .all_ok     (in_ready),
            .out_valid  (out_valid[i]),
            .done       (done_mask[i]),
            .ready_term (ready_terms_s[i])
        );
    end

    // Saturating count of cycles the upstream was held off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fanout_fork.sv
// Self-checking bench for fanout_fork: directed vector table, hand-written
// corner sequences, then randomized traffic against a token-level model.
module tb_fanout_fork;

    localparam int NF = 4;
    localparam int DW = 17;
    localparam int SW = 8;
    localparam int SB = 6;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            mode_eager;
    logic [NF-1:0]   en;
    logic [NF*SW-1:0] sel;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [NF-1:0]   out_valid;
    logic [DW-1:0]   out_data;
    logic [NF-1:0]   out_ready;
    logic [NF-1:0]   done_mask;
    logic [CW-1:0]   stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: which branches already hold the current token, and stall count.
    logic [NF-1:0] cur_act;
    logic [NF-1:0] m_taken;
    int            m_stall;
    logic [NF-1:0] m_ov;
    logic          m_ir;

    fanout_fork #(
        .NUM_FANOUT (NF),
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .SEL_BIT    (SB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .mode_eager (mode_eager),
        .en         (en),
        .sel        (sel),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done_mask  (done_mask),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          eager;
        logic [NF-1:0] en;
        logic [NF-1:0] act;
        logic          valid;
        logic [NF-1:0] rdy;
        logic          flush;
        logic [NF-1:0] exp_ov;
        logic          exp_ir;
        logic [NF-1:0] exp_done;
        logic [CW-1:0] exp_stall;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs; select fields get random filler with the routed bit forced.
    task automatic drive(input logic eager, input logic [NF-1:0] e, input logic [NF-1:0] act,
                         input logic v, input logic [NF-1:0] r, input logic f);
        logic [SW-1:0] b;
        mode_eager = eager;
        en         = e;
        in_valid   = v;
        out_ready  = r;
        flush      = f;
        in_data    = DW'($urandom);
        for (int i = 0; i < NF; i++) begin
            b          = SW'($urandom);
            b[SB]      = act[i];
            sel[i*SW +: SW] = b;
        end
        cur_act = e & act;
    endtask

    // Token-level view: pending = active branches still owed the token.
    task automatic model_eval();
        logic [NF-1:0] pending;
        if (mode_eager) begin
            pending = cur_act & ~m_taken;
            m_ov    = in_valid ? pending : '0;
            m_ir    = ((pending & ~out_ready) == '0);
        end else begin
            m_ir    = ((cur_act & ~out_ready) == '0);
            m_ov    = (in_valid && m_ir) ? cur_act : '0;
        end
    endtask

    task automatic model_update();
        if (flush) begin
            m_taken = '0;
            m_stall = 0;
        end else begin
            if (in_valid && !m_ir && m_stall < CNT_MAX) m_stall++;
            if (!mode_eager || (in_valid && m_ir)) m_taken = '0;
            else m_taken = m_taken | (m_ov & out_ready);
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_vs_model(input string tag);
        model_eval();
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".in_ready"},  32'(in_ready),  32'(m_ir));
        check({tag, ".out_data"},  32'(out_data),  32'(in_data));
        check({tag, ".done_mask"}, 32'(done_mask), 32'(m_taken));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0011, 1'b0, 4'b1111, 1'b0, 4'b0011, 4'd1};
        vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1100, 1'b0, 4'b1100, 1'b1, 4'b0000, 4'd1};
        vecs[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd2};
        vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1100, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd3};
        vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b0, 4'b1111, 1'b1, 4'b0000, 4'd3};
        vecs[5]  = '{1'b1, 4'b1111, 4'b1011, 1'b1, 4'b1011, 1'b0, 4'b1011, 1'b1, 4'b0000, 4'd3};
        vecs[6]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'd3};
        vecs[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'd3};
        vecs[8]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0101, 1'b0, 4'b1111, 1'b0, 4'b0101, 4'd4};
        vecs[9]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b1010, 1'b0, 4'b0000, 4'd0};
        vecs[10] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'd1};
        vecs[11] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 4'b1111, 1'b0, 4'b0001, 4'd2};
        vecs[12] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'd3};
        vecs[13] = '{1'b1, 4'b1111, 4'b0011, 1'b1, 4'b0001, 1'b0, 4'b0011, 1'b0, 4'b0001, 4'd4};
        vecs[14] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b0, 4'b1110, 1'b0, 4'b0011, 4'd5};
        vecs[15] = '{1'b1, 4'b1111, 4'b0011, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'd5};

        rst_n   = 1'b0;
        m_taken = '0;
        m_stall = 0;
        drive(1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        check("reset.done_mask", 32'(done_mask), 32'd0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].eager, vecs[k].en, vecs[k].act, vecs[k].valid, vecs[k].rdy, vecs[k].flush);
            #1;
            check($sformatf("vec%0d.out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
            check($sformatf("vec%0d.in_ready", k),  32'(in_ready),  32'(vecs[k].exp_ir));
            check($sformatf("vec%0d.out_data", k),  32'(out_data),  32'(in_data));
            tick();
            check($sformatf("vec%0d.done_mask", k), 32'(done_mask), 32'(vecs[k].exp_done));
            check($sformatf("vec%0d.stall_cnt", k), 32'(stall_cnt), 32'(vecs[k].exp_stall));
            @(negedge clk);
        end

        // Stall counter saturation, then flush.
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
            tick();
            check("sat.stall_model", 32'(stall_cnt), 32'(m_stall));
            @(negedge clk);
        end
        check("sat.stall_cnt", 32'(stall_cnt), 32'd15);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1);
        tick();
        check("flush.stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of a partially delivered token.
        drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0101, 1'b0);
        tick();
        check("rst.done_before", 32'(done_mask), 32'b0101);
        @(negedge clk);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.done_async", 32'(done_mask), 32'd0);
        check("rst.stall_async", 32'(stall_cnt), 32'd0);
        m_taken = '0;
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.out_valid_after", 32'(out_valid), 32'b1111);
        tick();
        @(negedge clk);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic eager;
            eager = (c % 37 < 26) ? 1'b1 : 1'b0;
            drive(eager,
                  ($urandom_range(0, 7) == 0) ? 4'(NF'($urandom)) : 4'b1111,
                  4'(NF'($urandom)) | 4'(NF'($urandom)),
                  ($urandom_range(0, 3) != 0),
                  4'(NF'($urandom)),
                  ($urandom_range(0, 31) == 0));
            #1;
            check_vs_model($sformatf("rnd%0d", c));
            tick();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fanout_fork.md
Name: fanout_fork

Overview:
- Parametrised ready/valid fork for the interconnect: one upstream stream is broadcast to NUM_FANOUT branch consumers.
- Generalises the combinational fanout ready-AND:
  - width and fanout are parameters;
  - per-branch sent tracking gives an eager mode, so a branch that accepts early is not re-presented the same token;
  - adds a saturating stall counter for debug and profiling.
- Sits between a switch-box/track mux output and its fanout destinations.

Parameters:
NUM_FANOUT, 20, number of branch consumers
DATA_WIDTH, 17, payload width broadcast to all branches
SEL_WIDTH, 8, width of each branch route-select field
SEL_BIT, 6, bit of the select field that marks the branch as routed
CNT_WIDTH, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of tracking state and stall counter
mode_eager  in  1  1 = eager fork, 0 = lazy fork
en  in  NUM_FANOUT  per-branch enable
sel  in  NUM_FANOUT*SEL_WIDTH  packed route-select fields; branch i occupies [i*SEL_WIDTH +: SEL_WIDTH]
in_valid  in  1  upstream valid
in_data  in  DATA_WIDTH  upstream payload
in_ready  out  1  upstream ready
out_valid  out  NUM_FANOUT  per-branch valid
out_data  out  DATA_WIDTH  broadcast payload
out_ready  in  NUM_FANOUT  per-branch ready
done_mask  out  NUM_FANOUT  branches that already took the current token (status)
stall_cnt  out  CNT_WIDTH  cycles with in_valid=1 and in_ready=0

Behaviour:
- Reset is asynchronous and active-low on rst_n. While rst_n=0: done_mask=0, stall_cnt=0.
- Active branch mask: active[i] = en[i] & sel[i][SEL_BIT].
- out_data = in_data, combinational, zero latency.
- Eager mode (mode_eager=1):
  - out_valid[i] = in_valid & active[i] & ~done[i].
  - in_ready = AND over i of (~active[i] | done[i] | out_ready[i]). It is independent of in_valid, so there is no comb loop.
  - fire[i] = out_valid[i] & out_ready[i].
  - complete = in_valid & in_ready. On complete, done <= 0.
  - Otherwise done[i] <= done[i] | fire[i].
  - A done branch sees out_valid=0 until the token completes.
- Lazy mode (mode_eager=0):
  - all_ok = AND over i of (~active[i] | out_ready[i]).
  - in_ready = all_ok.
  - out_valid[i] = in_valid & active[i] & all_ok.
  - done is forced to 0 every cycle.
- No active branches: in_ready=1, every out_valid=0. The token is consumed and dropped.
- Inactive branches never assert out_valid, and their out_ready is ignored.
- Config change mid-token: a done bit on a branch that becomes inactive is harmless and is cleared on completion.
  - A branch newly activated mid-token is presented the current token.
- Mode change:
  - eager→lazy clears done on the next edge;
  - lazy→eager starts with done=0.
- flush is synchronous and has priority over all updates: done<=0, stall_cnt<=0. Combinational outputs are unaffected.
- stall_cnt increments by 1 when in_valid & ~in_ready and saturates at all-ones. It never wraps.
- done_mask = done register.
- Reset asserted mid-token: all tracking is lost. The upstream token is re-presented to every branch after reset releases.
- The upstream must hold in_data stable while in_valid & ~in_ready. This is not checked by the block.

Decomposition:
- Package fanout_pkg:
  - SEL_BIT_DEFAULT constant;
  - fork_mode_e enum (FORK_LAZY=0, FORK_EAGER=1);
  - packed select-field typedef sel_t of SEL_WIDTH.
- Sub-module fanout_branch_tracker, one per branch via generate. Inputs: active, in_valid, out_ready, complete, mode, flush. Outputs: out_valid, done bit, per-branch ready term.
- The top ANDs the ready terms and holds the stall counter.

Test Plan:
- NUM_FANOUT=4, active=4'b1111, mode_eager=1, in_valid=1, out_ready=4'b0011 on cycle 0 then 4'b1100 on cycle 1 -> done_mask=4'b0011 after cycle 0, out_valid=4'b1100 on cycle 1, in_ready=1 on cycle 1, done_mask=0 after completion; each branch fires exactly once.
- Same stimulus with mode_eager=0 -> out_valid=0 and in_ready=0 on both cycles; token transfers only when out_ready=4'b1111, with out_valid=4'b1111 in that cycle.
- en=4'b1111, sel[2][6]=0, others 1, out_ready=4'b1011 -> branch 2 ignored; in_ready=1; out_valid[2]=0.
- en=0, in_valid=1 -> in_ready=1, out_valid=0, stall_cnt unchanged.
- CNT_WIDTH=4, in_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; flush pulse -> stall_cnt=0 next cycle.
- Eager, done_mask=4'b0101 mid-token, assert rst_n=0 asynchronously mid-cycle -> done_mask=0 immediately; after release, all 4 branches show out_valid=1.
